// File: rtl/uds_tile_loader_if.sv
// Row-source / UDS-side signal bundle for uds_tile_loader.
// master: row source that also observes the issued tile; slave: the loader.
interface uds_tile_loader_if #(
  parameter int unsigned A  = 64,
  parameter int unsigned DW = 16
);
  logic [8*DW-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic            in_last;
  logic [1:0]      cfg_scale_factor;
  logic [1:0]      cfg_function_mode;
  logic [A*DW-1:0] idata;
  logic            idata_valid;
  logic            active;
  logic [1:0]      scale_factor;
  logic [1:0]      function_mode;
  logic            busy;

  modport master (
    output in_data, in_valid, in_last, cfg_scale_factor, cfg_function_mode,
    input  in_ready, idata, idata_valid, active, scale_factor, function_mode, busy
  );

  modport slave (
    input  in_data, in_valid, in_last, cfg_scale_factor, cfg_function_mode,
    output in_ready, idata, idata_valid, active, scale_factor, function_mode, busy
  );
endinterface

// File: rtl/uds_tile_loader.sv
// uds_tile_loader: assembles 8-element rows into 8x8 tiles in a double-buffered
// bank pair and issues each tile to UDS as a one-cycle idata_valid/active pulse,
// spaced at least ISSUE_GAP cycles apart.
// Optional feature macro: UDS_EDGE_REPLICATE_EN -- when defined, rows padded on an
// early (in_last) close replicate the last accepted row; otherwise they are zero.
module uds_tile_loader #(
  parameter int unsigned A         = 64,
  parameter int unsigned DW        = 16,
  parameter int unsigned ISSUE_GAP = 3
) (
  input  logic              clk,
  input  logic              rst,
  uds_tile_loader_if.slave  bus
);

  localparam int unsigned ROWS = A / 8;
  localparam int unsigned RW   = 8 * DW;
  localparam int unsigned RCW  = $clog2(ROWS);

  typedef enum logic {IDLE, GAP} state_t;

  logic [RW-1:0]   bank_q [2][ROWS];
  logic [RW-1:0]   bank_d [2][ROWS];
  logic [1:0]      bsf_q [2];
  logic [1:0]      bsf_d [2];
  logic [1:0]      bfm_q [2];
  logic [1:0]      bfm_d [2];
  logic [1:0]      full_q, full_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [RCW-1:0]  row_cnt_q, row_cnt_d;
  logic [3:0]      gap_cnt_q, gap_cnt_d;
  state_t          state_q, state_d;
  logic [A*DW-1:0] idata_q, idata_d;
  logic            idata_valid_q, idata_valid_d;
  logic [1:0]      sf_q, sf_d;
  logic [1:0]      fm_q, fm_d;

  logic            in_ready;
  logic            accept;
  logic            close;
  logic [RW-1:0]   pad_row;

  assign in_ready = !rst && !full_q[wr_ptr_q];
  assign accept   = bus.in_valid && in_ready;
  assign close    = accept && (bus.in_last || (row_cnt_q == RCW'(ROWS - 1)));

`ifdef UDS_EDGE_REPLICATE_EN
  assign pad_row = bus.in_data;
`else
  assign pad_row = '0;
`endif

  // Row write / tile close on the fill side, issue FSM on the drain side.
  // Close and issue always touch different banks: close needs full[wr]==0,
  // issue needs full[rd]==1, so both may update full_d in the same cycle.
  always_comb begin
    bank_d        = bank_q;
    bsf_d         = bsf_q;
    bfm_d         = bfm_q;
    full_d        = full_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    row_cnt_d     = row_cnt_q;
    state_d       = state_q;
    gap_cnt_d     = gap_cnt_q;
    idata_d       = idata_q;
    idata_valid_d = 1'b0;
    sf_d          = sf_q;
    fm_d          = fm_q;

    if (accept) begin
      bank_d[wr_ptr_q][row_cnt_q] = bus.in_data;
      if (row_cnt_q == '0) begin
        bsf_d[wr_ptr_q] = bus.cfg_scale_factor;
        bfm_d[wr_ptr_q] = bus.cfg_function_mode;
      end
      if (close) begin
        for (int unsigned r = 0; r < ROWS; r++) begin
          if (r > 32'(row_cnt_q)) begin
            bank_d[wr_ptr_q][r] = pad_row;
          end
        end
        full_d[wr_ptr_q] = 1'b1;
        wr_ptr_d         = ~wr_ptr_q;
        row_cnt_d        = '0;
      end else begin
        row_cnt_d = row_cnt_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (full_q[rd_ptr_q]) begin
          for (int unsigned r = 0; r < ROWS; r++) begin
            idata_d[r*RW +: RW] = bank_q[rd_ptr_q][r];
          end
          sf_d             = bsf_q[rd_ptr_q];
          fm_d             = bfm_q[rd_ptr_q];
          idata_valid_d    = 1'b1;
          full_d[rd_ptr_q] = 1'b0;
          rd_ptr_d         = ~rd_ptr_q;
          gap_cnt_d        = 4'(ISSUE_GAP - 1);
          state_d          = (ISSUE_GAP > 1) ? GAP : IDLE;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q - 1'b1;
        if (gap_cnt_d == '0) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State registers; reset discards every partial and full bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q        <= '{default: '0};
      bsf_q         <= '{default: '0};
      bfm_q         <= '{default: '0};
      full_q        <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      row_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      state_q       <= IDLE;
      idata_q       <= '0;
      idata_valid_q <= 1'b0;
      sf_q          <= '0;
      fm_q          <= '0;
    end else begin
      bank_q        <= bank_d;
      bsf_q         <= bsf_d;
      bfm_q         <= bfm_d;
      full_q        <= full_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      row_cnt_q     <= row_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      state_q       <= state_d;
      idata_q       <= idata_d;
      idata_valid_q <= idata_valid_d;
      sf_q          <= sf_d;
      fm_q          <= fm_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.idata         = idata_q;
  assign bus.idata_valid   = idata_valid_q;
  assign bus.active        = idata_valid_q;
  assign bus.scale_factor  = sf_q;
  assign bus.function_mode = fm_q;
  assign bus.busy          = (|full_q) || (row_cnt_q != '0) || (state_q == GAP);

endmodule

// File: tb/tb_uds_tile_loader.sv
// Bench for uds_tile_loader: two instances (ISSUE_GAP 3 and 12), a reference
// tile model feeding per-instance scoreboards, and per-scenario tasks.
module tb_uds_tile_loader;

  localparam int unsigned A    = 64;
  localparam int unsigned DW   = 16;
  localparam int unsigned ROWS = 8;
  localparam int unsigned RW   = 8 * DW;

  typedef struct {
    logic [A*DW-1:0] data;
    logic [1:0]      sf;
    logic [1:0]      fm;
  } tile_t;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #5 clk = ~clk;

  uds_tile_loader_if #(.A(A), .DW(DW)) bus_a ();
  uds_tile_loader_if #(.A(A), .DW(DW)) bus_b ();

  uds_tile_loader #(.A(A), .DW(DW), .ISSUE_GAP(3)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a.slave)
  );

  uds_tile_loader #(.A(A), .DW(DW), .ISSUE_GAP(12)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b.slave)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  tile_t exp_a[$];
  tile_t exp_b[$];
  int    pulses_a[$];
  int    pulses_b[$];

  logic [RW-1:0]   m_rows [2][ROWS];
  int              m_idx  [2];
  logic [1:0]      m_sf   [2];
  logic [1:0]      m_fm   [2];
  logic [A*DW-1:0] last_data [2];

  bit saw_stall;
  int stall_after;
  int accepts;

  task automatic set_in(input int s, input logic v, input logic [RW-1:0] d,
                        input logic last, input logic [1:0] sf, input logic [1:0] fm);
    if (s == 0) begin
      bus_a.in_valid = v; bus_a.in_data = d; bus_a.in_last = last;
      bus_a.cfg_scale_factor = sf; bus_a.cfg_function_mode = fm;
    end else begin
      bus_b.in_valid = v; bus_b.in_data = d; bus_b.in_last = last;
      bus_b.cfg_scale_factor = sf; bus_b.cfg_function_mode = fm;
    end
  endtask

  task automatic monitor_one(input int s);
    logic            vld, act;
    logic [A*DW-1:0] d;
    logic [1:0]      sf, fm;
    tile_t           e;
    bit              have;
    int              bad;
    if (s == 0) begin
      vld = bus_a.idata_valid; act = bus_a.active; d = bus_a.idata;
      sf = bus_a.scale_factor; fm = bus_a.function_mode;
    end else begin
      vld = bus_b.idata_valid; act = bus_b.active; d = bus_b.idata;
      sf = bus_b.scale_factor; fm = bus_b.function_mode;
    end
    checks++;
    if (act !== vld) begin
      errors++;
      $display("FAIL active_coincident dut%0d cyc=%0d active=%b required=%b", s, cyc, act, vld);
    end
    if (vld === 1'b1) begin
      if (s == 0) pulses_a.push_back(cyc); else pulses_b.push_back(cyc);
      have = 1'b0;
      if (s == 0 && exp_a.size() > 0) begin e = exp_a.pop_front(); have = 1'b1; end
      if (s == 1 && exp_b.size() > 0) begin e = exp_b.pop_front(); have = 1'b1; end
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL unexpected_pulse dut%0d cyc=%0d idata_valid=1 required=0 (no tile pending)", s, cyc);
      end else begin
        last_data[s] = e.data;
        if (d !== e.data) begin
          errors++;
          bad = 0;
          for (int r = ROWS - 1; r >= 0; r--) begin
            if (d[r*RW +: RW] !== e.data[r*RW +: RW]) bad = r;
          end
          $display("FAIL tile_data dut%0d cyc=%0d row%0d got=%h required=%h",
                   s, cyc, bad, d[bad*RW +: RW], e.data[bad*RW +: RW]);
        end
        checks++;
        if (sf !== e.sf) begin
          errors++;
          $display("FAIL tile_scale_factor dut%0d cyc=%0d got=%0d required=%0d", s, cyc, sf, e.sf);
        end
        checks++;
        if (fm !== e.fm) begin
          errors++;
          $display("FAIL tile_function_mode dut%0d cyc=%0d got=%b required=%b", s, cyc, fm, e.fm);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    monitor_one(0);
    monitor_one(1);
  endtask

  task automatic idle(input int s, input int n);
    set_in(s, 1'b0, '0, 1'b0, 2'b00, 2'b00);
    repeat (n) step();
  endtask

  // Reference tile assembly: pushes the expected tile when a row closes it.
  task automatic model_accept(input int s, input logic [RW-1:0] d, input logic last,
                              input logic [1:0] sf, input logic [1:0] fm);
    logic [RW-1:0] pad;
    tile_t         t;
    if (m_idx[s] == 0) begin
      m_sf[s] = sf;
      m_fm[s] = fm;
    end
    m_rows[s][m_idx[s]] = d;
    if (last || m_idx[s] == ROWS - 1) begin
`ifdef UDS_EDGE_REPLICATE_EN
      pad = d;
`else
      pad = '0;
`endif
      for (int r = 0; r < ROWS; r++) begin
        t.data[r*RW +: RW] = (r <= m_idx[s]) ? m_rows[s][r] : pad;
      end
      t.sf = m_sf[s];
      t.fm = m_fm[s];
      if (s == 0) exp_a.push_back(t); else exp_b.push_back(t);
      m_idx[s] = 0;
    end else begin
      m_idx[s]++;
    end
  endtask

  task automatic push_row(input int s, input logic [RW-1:0] d, input logic last,
                          input logic [1:0] sf, input logic [1:0] fm, output int acc_cyc);
    bit   done   = 1'b0;
    int   budget = 200;
    logic rdy;
    acc_cyc = -1;
    set_in(s, 1'b1, d, last, sf, fm);
    while (!done && budget > 0) begin
      rdy = (s == 0) ? bus_a.in_ready : bus_b.in_ready;
      if (rdy !== 1'b1 && !saw_stall) begin
        saw_stall   = 1'b1;
        stall_after = accepts;
      end
      step();
      budget--;
      if (rdy === 1'b1) begin
        done    = 1'b1;
        acc_cyc = cyc;
        accepts++;
        model_accept(s, d, last, sf, fm);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d cyc=%0d in_ready stayed low, required an accept", s, cyc);
    end
  endtask

  task automatic wait_pulses(input int s, input int n, input int budget);
    int b = budget;
    int got;
    got = (s == 0) ? pulses_a.size() : pulses_b.size();
    while (got < n && b > 0) begin
      step();
      b--;
      got = (s == 0) ? pulses_a.size() : pulses_b.size();
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL pulse_count dut%0d cyc=%0d got=%0d required=%0d", s, cyc, got, n);
    end
  endtask

  function automatic logic [RW-1:0] row_of(input logic [15:0] v);
    return {8{v}};
  endfunction

  task automatic test_reset();
    set_in(0, 1'b0, '0, 1'b0, 2'b00, 2'b00);
    set_in(1, 1'b0, '0, 1'b0, 2'b00, 2'b00);
    rst_a = 1'b1;
    rst_b = 1'b1;
    m_idx[0] = 0;
    m_idx[1] = 0;
    step();
    step();
    checks++;
    if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_a got=%b required=0", bus_a.in_ready); end
    checks++;
    if (bus_b.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_b got=%b required=0", bus_b.in_ready); end
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    checks++;
    if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready_a got=%b required=1", bus_a.in_ready); end
    checks++;
    if (bus_b.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready_b got=%b required=1", bus_b.in_ready); end
    checks++;
    if (bus_a.idata !== '0) begin errors++; $display("FAIL reset_idata got=%h required=0", bus_a.idata[RW-1:0]); end
    checks++;
    if (bus_a.idata_valid !== 1'b0) begin errors++; $display("FAIL reset_idata_valid got=%b required=0", bus_a.idata_valid); end
    checks++;
    if (bus_a.scale_factor !== 2'b00) begin errors++; $display("FAIL reset_scale_factor got=%b required=00", bus_a.scale_factor); end
    checks++;
    if (bus_a.function_mode !== 2'b00) begin errors++; $display("FAIL reset_function_mode got=%b required=00", bus_a.function_mode); end
    checks++;
    if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b required=0", bus_a.busy); end
  endtask

  task automatic test_single_tile();
    int t = 0;
    pulses_a.delete();
    for (int r = 0; r < ROWS; r++) begin
      push_row(0, row_of(16'h0100 + 16'(r)), 1'b0, 2'b00, 2'b10, t);
    end
    set_in(0, 1'b0, '0, 1'b0, 2'b00, 2'b00);
    wait_pulses(0, 1, 20);
    if (pulses_a.size() >= 1) begin
      checks++;
      if (pulses_a[0] != t + 1) begin
        errors++;
        $display("FAIL single_latency pulse_cyc=%0d required=%0d", pulses_a[0], t + 1);
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      checks++;
      if (bus_a.idata[r*RW +: 16] !== 16'h0100 + 16'(r)) begin
        errors++;
        $display("FAIL single_row%0d got=%h required=%h", r, bus_a.idata[r*RW +: 16], 16'h0100 + 16'(r));
      end
    end
    checks++;
    if (bus_a.function_mode !== 2'b10) begin errors++; $display("FAIL single_function_mode got=%b required=10", bus_a.function_mode); end
    idle(0, 5);
    checks++;
    if (bus_a.idata !== last_data[0]) begin errors++; $display("FAIL idata_hold row0 got=%h required=%h", bus_a.idata[RW-1:0], last_data[0][RW-1:0]); end
  endtask

  task automatic test_back_to_back();
    int            t = 0;
    logic [RW-1:0] d;
    pulses_a.delete();
    saw_stall = 1'b0;
    accepts   = 0;
    for (int i = 0; i < 32; i++) begin
      for (int e = 0; e < 8; e++) d[e*DW +: DW] = 16'h2000 | 16'(i * 8 + e);
      push_row(0, d, 1'b0, 2'b01, 2'b01, t);
    end
    set_in(0, 1'b0, '0, 1'b0, 2'b00, 2'b00);
    wait_pulses(0, 4, 40);
    for (int k = 1; k < pulses_a.size(); k++) begin
      checks++;
      if (pulses_a[k] - pulses_a[k-1] != 8) begin
        errors++;
        $display("FAIL b2b_spacing pulse%0d got=%0d required=8", k, pulses_a[k] - pulses_a[k-1]);
      end
    end
    checks++;
    if (saw_stall) begin errors++; $display("FAIL b2b_in_ready stall_after=%0d required=no stall", stall_after); end
  endtask

  task automatic test_backpressure();
    int            t = 0;
    logic [RW-1:0] d;
    pulses_b.delete();
    saw_stall   = 1'b0;
    stall_after = -1;
    accepts     = 0;
    for (int i = 0; i < 48; i++) begin
      for (int e = 0; e < 8; e++) d[e*DW +: DW] = 16'h9000 | 16'(i * 8 + e);
      push_row(1, d, 1'b0, 2'b11, 2'b01, t);
    end
    set_in(1, 1'b0, '0, 1'b0, 2'b00, 2'b00);
    wait_pulses(1, 6, 200);
    for (int k = 1; k < pulses_b.size(); k++) begin
      checks++;
      if (pulses_b[k] - pulses_b[k-1] != 12) begin
        errors++;
        $display("FAIL gap12_spacing pulse%0d got=%0d required=12", k, pulses_b[k] - pulses_b[k-1]);
      end
    end
    checks++;
    if (!saw_stall) begin errors++; $display("FAIL gap12_stall got=no stall required=stall"); end
    checks++;
    if (stall_after != 32) begin errors++; $display("FAIL gap12_first_stall after_accepts=%0d required=32", stall_after); end
  endtask

  task automatic test_in_last();
    int          t = 0;
    logic [15:0] padv;
    pulses_a.delete();
    push_row(0, row_of(16'hAAAA), 1'b0, 2'b00, 2'b00, t);
    push_row(0, row_of(16'hBBBB), 1'b0, 2'b00, 2'b00, t);
    push_row(0, row_of(16'hCCCC), 1'b1, 2'b00, 2'b00, t);
    set_in(0, 1'b0, '0, 1'b0, 2'b00, 2'b00);
    wait_pulses(0, 1, 20);
`ifdef UDS_EDGE_REPLICATE_EN
    padv = 16'hCCCC;
`else
    padv = 16'h0000;
`endif
    for (int r = 3; r < ROWS; r++) begin
      checks++;
      if (bus_a.idata[r*RW +: RW] !== row_of(padv)) begin
        errors++;
        $display("FAIL last_pad_row%0d got=%h required=%h", r, bus_a.idata[r*RW +: 16], padv);
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      push_row(0, row_of(16'h3000 + 16'(r)), 1'b0, 2'b01, 2'b00, t);
    end
    set_in(0, 1'b0, '0, 1'b0, 2'b00, 2'b00);
    wait_pulses(0, 2, 30);
    checks++;
    if (bus_a.scale_factor !== 2'b01) begin errors++; $display("FAIL tile2_scale_factor got=%0d required=1", bus_a.scale_factor); end
    push_row(0, row_of(16'h4444), 1'b1, 2'b10, 2'b11, t);
    set_in(0, 1'b0, '0, 1'b0, 2'b00, 2'b00);
    wait_pulses(0, 3, 20);
`ifdef UDS_EDGE_REPLICATE_EN
    padv = 16'h4444;
`else
    padv = 16'h0000;
`endif
    checks++;
    if (bus_a.idata[7*RW +: RW] !== row_of(padv)) begin
      errors++;
      $display("FAIL last_row0_pad got=%h required=%h", bus_a.idata[7*RW +: 16], padv);
    end
  endtask

  task automatic test_cfg_change();
    int t = 0;
    pulses_a.delete();
    for (int r = 0; r < ROWS; r++) begin
      push_row(0, row_of(16'h5500 + 16'(r)), 1'b0, 2'b00, (r < 4) ? 2'b00 : 2'b01, t);
    end
    set_in(0, 1'b0, '0, 1'b0, 2'b00, 2'b00);
    wait_pulses(0, 1, 20);
    checks++;
    if (bus_a.function_mode !== 2'b00) begin errors++; $display("FAIL cfg_sampled_first_row got=%b required=00", bus_a.function_mode); end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    idle(1, 20);
    pulses_b.delete();
    for (int r = 0; r < ROWS; r++) push_row(1, row_of(16'h5000 + 16'(r)), 1'b0, 2'b10, 2'b11, t);
    for (int r = 0; r < 3; r++)    push_row(1, row_of(16'h6000 + 16'(r)), (r == 2), 2'b01, 2'b01, t);
    for (int r = 0; r < 5; r++)    push_row(1, row_of(16'h7000 + 16'(r)), 1'b0, 2'b01, 2'b10, t);
    set_in(1, 1'b0, '0, 1'b0, 2'b00, 2'b00);
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    exp_b.delete();
    m_idx[1] = 0;
    #1;
    checks++;
    if (pulses_b.size() != 1) begin errors++; $display("FAIL rstmid_pulses_before got=%0d required=1", pulses_b.size()); end
    checks++;
    if (bus_b.idata !== '0) begin errors++; $display("FAIL rstmid_idata got=%h required=0", bus_b.idata[RW-1:0]); end
    checks++;
    if (bus_b.scale_factor !== 2'b00 || bus_b.function_mode !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_cfg_out got=%b/%b required=00/00", bus_b.scale_factor, bus_b.function_mode);
    end
    checks++;
    if (bus_b.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b required=0", bus_b.busy); end
    checks++;
    if (bus_b.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got=%b required=1", bus_b.in_ready); end
    idle(1, 20);
    checks++;
    if (pulses_b.size() != 1) begin errors++; $display("FAIL rstmid_no_stale_pulse got=%0d required=1", pulses_b.size()); end
    for (int r = 0; r < ROWS; r++) push_row(1, row_of(16'h8000 + 16'(r)), 1'b0, 2'b11, 2'b10, t);
    set_in(1, 1'b0, '0, 1'b0, 2'b00, 2'b00);
    wait_pulses(1, 2, 30);
    if (pulses_b.size() >= 2) begin
      checks++;
      if (pulses_b[1] != t + 1) begin
        errors++;
        $display("FAIL rstmid_fresh_latency pulse_cyc=%0d required=%0d", pulses_b[1], t + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_back_to_back();
    test_backpressure();
    test_in_last();
    test_cfg_change();
    test_reset_mid();
    idle(0, 5);
    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      errors++;
      $display("FAIL leftover_tiles got=%0d/%0d required=0/0", exp_a.size(), exp_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d simulation did not complete", cyc);
    $fatal(1, "watchdog");
  end

endmodule
